grant_bus_mux: RTL and testbench
================================

Name: grant_bus_mux

Overview:
- Sits directly downstream of the 4-agent request/grant arbiter FSM.
- Consumes the arbiter's four active-high grant lines and steers the granted agent's valid/data beats onto one shared output bus.
- Tracks the owner and counts beats per tenure, capping each tenure at MAX_BEATS.
- Flags overruns and any grant pattern that is not one-hot.

Parameters:
- DATA_W, 8, width of each agent data bus and of bus_data.
- MAX_BEATS, 16, maximum beats forwarded per grant tenure (1..2^CNT_W-1).
- CNT_W, 5, width of the beat counter.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- gnt_0..gnt_3  input  1 each  grants from the arbiter; one-hot or all zero expected.
- valid_0..valid_3  input  1 each  agent n presents a beat this cycle.
- data_0..data_3  input  DATA_W each  agent n beat payload.
- bus_valid  output  1  registered; bus_data holds a forwarded beat.
- bus_data  output  DATA_W  registered payload.
- bus_owner  output  2  index of the current owner; valid while bus_busy=1.
- bus_busy  output  1  high in the OWNED and COOLDOWN states.
- beat_count  output  CNT_W  beats forwarded in the current tenure.
- overrun  output  1  sticky per tenure; owner offered a beat while beat_count==MAX_BEATS.
- grant_err  output  1  one-cycle pulse on an illegal grant pattern.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is `reset`, synchronous and active-high. Reset is sampled only at the rising edge of `clock`; there is no asynchronous path.
- Reset values:
  - state=IDLE.
  - All outputs 0, including bus_data and bus_owner.
  - Reset has priority over every other event. Asserting it mid-tenure aborts the tenure immediately with no cooldown.
- States: IDLE, OWNED, COOLDOWN (2-bit encoding).
- IDLE:
  - Exactly one gnt_n=1: latch owner=n, beat_count<=0, overrun<=0, go to OWNED. No beat is forwarded on this capture edge; agents start presenting beats one cycle after grant.
  - More than one gnt high: grant_err<=1 for one cycle, stay in IDLE.
  - All grants low: stay in IDLE.
- OWNED, evaluated each edge in priority order:
  1. Any gnt_m=1 with m!=owner: grant_err pulse, go to COOLDOWN, nothing forwarded.
  2. gnt_owner=0: go to COOLDOWN, nothing forwarded. A valid_owner present on that edge is dropped.
  3. Otherwise, if valid_owner=1 and beat_count<MAX_BEATS: bus_valid<=1, bus_data<=data_owner, beat_count<=beat_count+1.
  4. Otherwise, if valid_owner=1 and beat_count==MAX_BEATS: beat dropped, bus_valid<=0, overrun<=1 (sticky).
  5. Otherwise: bus_valid<=0.
- bus_data holds its last value whenever bus_valid<=0.
- Latency: a beat sampled at edge k appears on bus_valid/bus_data after edge k; one register stage.
- COOLDOWN:
  - Lasts exactly one cycle, then goes to IDLE.
  - bus_valid=0. beat_count, overrun and bus_owner hold for observation.
  - Grants are ignored, so a new grant on this edge is not captured; it is re-sampled in IDLE.
- Entering IDLE: bus_busy<=0. beat_count and overrun clear at the next capture, not on IDLE entry.
- Valid/data from non-owners are always ignored.
- beat_count never exceeds MAX_BEATS; there is no wrap.
- Back-to-back tenures: minimum gap is grant drop edge, COOLDOWN edge, then IDLE capture. This matches the arbiter's IDLE pass between grants.

Test Plan:
1. Reset: hold reset high 3 cycles while gnt_1=1 and valid_1=1 -> all outputs 0; after release, capture owner 1 on the first edge.
2. Normal tenure: gnt_2=1; at cycles 1..3 valid_2=1 with data 0xA1, 0xA2, 0xA3 -> bus_valid pulses 3 cycles with those values, one cycle late; beat_count=3; bus_owner=2. Drop gnt_2 -> bus_busy=1 through COOLDOWN, then 0.
3. Overrun (MAX_BEATS=16): gnt_0 held with valid_0 continuous for 20 cycles -> exactly 16 beats forwarded, beat_count=16, overrun=1 from the 17th offered beat, bus_valid=0 thereafter. Next tenure clears overrun.
4. Illegal grants: gnt_1=1 and gnt_3=1 together in IDLE -> grant_err one-cycle pulse, state stays IDLE. In OWNED(owner 0), raise gnt_3 -> grant_err pulse, COOLDOWN, nothing forwarded.
5. Non-owner filtering: owner 1, valid_0=1 with data 0x55 and valid_1=0 -> bus_valid stays 0.
6. Mid-tenure reset: after 5 beats on owner 3, assert reset 1 cycle -> next edge returns to IDLE with all outputs 0. Regrant gnt_3 -> beat_count restarts at 0.

Source files
------------

// File: rtl/grant_bus_mux.sv
// Output steering stage behind the 4-agent arbiter: forwards the granted agent's
// beats onto one registered bus, counts beats per tenure and flags overruns and bad grants.
module grant_bus_mux #(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              gnt_0,
  input  logic              gnt_1,
  input  logic              gnt_2,
  input  logic              gnt_3,
  input  logic              valid_0,
  input  logic              valid_1,
  input  logic              valid_2,
  input  logic              valid_3,
  input  logic [DATA_W-1:0] data_0,
  input  logic [DATA_W-1:0] data_1,
  input  logic [DATA_W-1:0] data_2,
  input  logic [DATA_W-1:0] data_3,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic [1:0]        bus_owner,
  output logic              bus_busy,
  output logic [CNT_W-1:0]  beat_count,
  output logic              overrun,
  output logic              grant_err
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OWNED    = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

  state_t             r_state;
  logic [1:0]         r_owner;
  logic [CNT_W-1:0]   r_count;
  logic               r_overrun;
  logic               r_bus_valid;
  logic [DATA_W-1:0]  r_bus_data;
  logic               r_grant_err;

  logic [3:0]         w_gnt;
  logic [3:0]         w_valid;
  logic [DATA_W-1:0]  w_data [4];
  logic [2:0]         w_ngnt;
  logic [1:0]         w_gnt_idx;
  logic [3:0]         w_own_mask;
  logic               w_own_gnt;
  logic               w_other_gnt;
  logic               w_at_max;

  always_comb begin
    w_gnt     = {gnt_3, gnt_2, gnt_1, gnt_0};
    w_valid   = {valid_3, valid_2, valid_1, valid_0};
    w_data[0] = data_0;
    w_data[1] = data_1;
    w_data[2] = data_2;
    w_data[3] = data_3;
  end

  // Population count plus index of the (last) set grant; index is only used when count==1.
  always_comb begin
    w_ngnt    = '0;
    w_gnt_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_gnt[i]) begin
        w_ngnt    = w_ngnt + 3'd1;
        w_gnt_idx = i[1:0];
      end
    end
  end

  always_comb begin
    w_own_mask  = 4'b0001 << r_owner;
    w_own_gnt   = w_gnt[r_owner];
    w_other_gnt = |(w_gnt & ~w_own_mask);
    w_at_max    = (r_count == CNT_W'(MAX_BEATS));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_owner     <= '0;
      r_count     <= '0;
      r_overrun   <= 1'b0;
      r_bus_valid <= 1'b0;
      r_bus_data  <= '0;
      r_grant_err <= 1'b0;
    end else begin
      r_bus_valid <= 1'b0;
      r_grant_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ngnt == 3'd1) begin
            r_owner   <= w_gnt_idx;
            r_count   <= '0;
            r_overrun <= 1'b0;
            r_state   <= ST_OWNED;
          end else if (w_ngnt > 3'd1) begin
            r_grant_err <= 1'b1;
          end
        end
        ST_OWNED: begin
          if (w_other_gnt) begin
            r_grant_err <= 1'b1;
            r_state     <= ST_COOLDOWN;
          end else if (!w_own_gnt) begin
            r_state <= ST_COOLDOWN;
          end else if (w_valid[r_owner]) begin
            if (!w_at_max) begin
              r_bus_valid <= 1'b1;
              r_bus_data  <= w_data[r_owner];
              r_count     <= r_count + 1'b1;
            end else begin
              r_overrun <= 1'b1;
            end
          end
        end
        ST_COOLDOWN: r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus_valid  = r_bus_valid;
  assign bus_data   = r_bus_data;
  assign bus_owner  = r_owner;
  assign bus_busy   = (r_state != ST_IDLE);
  assign beat_count = r_count;
  assign overrun    = r_overrun;
  assign grant_err  = r_grant_err;

endmodule

// File: tb/tb_grant_bus_mux.sv
// Scenario-driven bench for grant_bus_mux; forwarded beats are checked against a
// queue of expected payloads filled as stimulus is driven.
module tb_grant_bus_mux;

  localparam int DATA_W    = 8;
  localparam int MAX_BEATS = 16;
  localparam int CNT_W     = 5;

  logic              clock = 1'b0;
  logic              reset;
  logic              gnt_0, gnt_1, gnt_2, gnt_3;
  logic              valid_0, valid_1, valid_2, valid_3;
  logic [DATA_W-1:0] data_0, data_1, data_2, data_3;
  logic              bus_valid;
  logic [DATA_W-1:0] bus_data;
  logic [1:0]        bus_owner;
  logic              bus_busy;
  logic [CNT_W-1:0]  beat_count;
  logic              overrun;
  logic              grant_err;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DATA_W-1:0] sb_q [$];

  grant_bus_mux #(.DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .gnt_2(gnt_2), .gnt_3(gnt_3),
    .valid_0(valid_0), .valid_1(valid_1), .valid_2(valid_2), .valid_3(valid_3),
    .data_0(data_0), .data_1(data_1), .data_2(data_2), .data_3(data_3),
    .bus_valid(bus_valid), .bus_data(bus_data), .bus_owner(bus_owner),
    .bus_busy(bus_busy), .beat_count(beat_count), .overrun(overrun),
    .grant_err(grant_err)
  );

  always #5 clock = ~clock;

  // Every forwarded beat must match the oldest outstanding expected payload.
  always @(posedge clock) begin
    #1;
    if (bus_valid === 1'b1) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_unexpected_beat: got data %h, expected no beat", bus_data);
      end else begin
        logic [DATA_W-1:0] exp_d;
        exp_d = sb_q.pop_front();
        if (bus_data !== exp_d)
          $display("FAIL sb_beat_data: got %h, expected %h", bus_data, exp_d);
        else
          n_pass++;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    {gnt_0, gnt_1, gnt_2, gnt_3} = '0;
    {valid_0, valid_1, valid_2, valid_3} = '0;
    data_0 = '0; data_1 = '0; data_2 = '0; data_3 = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    gnt_1 = 1'b1; valid_1 = 1'b1; data_1 = 8'h77;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if ({bus_valid, bus_data, bus_owner, bus_busy, beat_count, overrun, grant_err} !== '0)
        $display("FAIL reset_outputs: cycle %0d got v=%b d=%h o=%0d busy=%b cnt=%0d ovr=%b err=%b, expected all 0",
                 c, bus_valid, bus_data, bus_owner, bus_busy, beat_count, overrun, grant_err);
      else n_pass++;
    end
    reset = 1'b0;
    step();
    n_checks++;
    if (bus_busy !== 1'b1 || bus_owner !== 2'd1 || beat_count !== '0 || bus_valid !== 1'b0)
      $display("FAIL reset_capture: got busy=%b owner=%0d cnt=%0d v=%b, expected busy=1 owner=1 cnt=0 v=0",
               bus_busy, bus_owner, beat_count, bus_valid);
    else n_pass++;
    clear_inputs();
    step();
    step();
    n_checks++;
    if (bus_busy !== 1'b0) $display("FAIL reset_release_idle: got busy=%b, expected 0", bus_busy);
    else n_pass++;
  endtask

  task automatic test_normal();
    gnt_2 = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      valid_2 = 1'b1;
      data_2  = 8'hA1 + 8'(i);
      sb_q.push_back(data_2);
      step();
      n_checks++;
      if (beat_count !== CNT_W'(i + 1))
        $display("FAIL normal_count: got %0d, expected %0d", beat_count, i + 1);
      else n_pass++;
    end
    valid_2 = 1'b0;
    step();
    n_checks++;
    if (bus_valid !== 1'b0 || beat_count !== CNT_W'(3) || bus_owner !== 2'd2 || bus_data !== 8'hA3)
      $display("FAIL normal_after: got v=%b cnt=%0d owner=%0d d=%h, expected v=0 cnt=3 owner=2 d=a3",
               bus_valid, beat_count, bus_owner, bus_data);
    else n_pass++;
    gnt_2 = 1'b0;
    step();
    n_checks++;
    if (bus_busy !== 1'b1 || beat_count !== CNT_W'(3) || bus_valid !== 1'b0)
      $display("FAIL normal_cooldown: got busy=%b cnt=%0d v=%b, expected busy=1 cnt=3 v=0",
               bus_busy, beat_count, bus_valid);
    else n_pass++;
    step();
    n_checks++;
    if (bus_busy !== 1'b0) $display("FAIL normal_idle: got busy=%b, expected 0", bus_busy);
    else n_pass++;
  endtask

  task automatic test_overrun();
    int exp_cnt;
    gnt_0 = 1'b1;
    step();
    valid_0 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data_0 = 8'(8'h10 + i);
      if (i < MAX_BEATS) sb_q.push_back(data_0);
      step();
      exp_cnt = (i + 1 < MAX_BEATS) ? i + 1 : MAX_BEATS;
      n_checks++;
      if (beat_count !== CNT_W'(exp_cnt) || overrun !== (i >= MAX_BEATS))
        $display("FAIL overrun_beat%0d: got cnt=%0d ovr=%b, expected cnt=%0d ovr=%b",
                 i, beat_count, overrun, exp_cnt, (i >= MAX_BEATS));
      else n_pass++;
    end
    clear_inputs();
    step();
    step();
    gnt_0 = 1'b1;
    step();
    n_checks++;
    if (overrun !== 1'b0 || beat_count !== '0 || bus_busy !== 1'b1)
      $display("FAIL overrun_next_tenure: got ovr=%b cnt=%0d busy=%b, expected ovr=0 cnt=0 busy=1",
               overrun, beat_count, bus_busy);
    else n_pass++;
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_illegal();
    gnt_1 = 1'b1; gnt_3 = 1'b1;
    step();
    n_checks++;
    if (grant_err !== 1'b1 || bus_busy !== 1'b0)
      $display("FAIL illegal_idle: got err=%b busy=%b, expected err=1 busy=0", grant_err, bus_busy);
    else n_pass++;
    clear_inputs();
    step();
    n_checks++;
    if (grant_err !== 1'b0 || bus_busy !== 1'b0)
      $display("FAIL illegal_idle_pulse: got err=%b busy=%b, expected err=0 busy=0", grant_err, bus_busy);
    else n_pass++;
    gnt_0 = 1'b1;
    step();
    gnt_3 = 1'b1; valid_0 = 1'b1; data_0 = 8'h99;
    step();
    n_checks++;
    if (grant_err !== 1'b1 || bus_busy !== 1'b1 || bus_valid !== 1'b0 || bus_owner !== 2'd0)
      $display("FAIL illegal_owned: got err=%b busy=%b v=%b owner=%0d, expected err=1 busy=1 v=0 owner=0",
               grant_err, bus_busy, bus_valid, bus_owner);
    else n_pass++;
    clear_inputs();
    step();
    n_checks++;
    if (grant_err !== 1'b0 || bus_busy !== 1'b0)
      $display("FAIL illegal_recover: got err=%b busy=%b, expected err=0 busy=0", grant_err, bus_busy);
    else n_pass++;
  endtask

  task automatic test_nonowner();
    gnt_1 = 1'b1;
    step();
    valid_0 = 1'b1; data_0 = 8'h55;
    valid_2 = 1'b1; data_2 = 8'h66;
    valid_3 = 1'b1; data_3 = 8'h77;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (bus_valid !== 1'b0 || beat_count !== '0)
        $display("FAIL nonowner_filter: got v=%b cnt=%0d, expected v=0 cnt=0", bus_valid, beat_count);
      else n_pass++;
    end
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_midreset();
    gnt_3 = 1'b1;
    step();
    valid_3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_3 = 8'(8'hC0 + i);
      sb_q.push_back(data_3);
      step();
    end
    valid_3 = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if ({bus_valid, bus_data, bus_owner, bus_busy, beat_count, overrun, grant_err} !== '0)
      $display("FAIL midreset_outputs: got v=%b d=%h o=%0d busy=%b cnt=%0d ovr=%b err=%b, expected all 0",
               bus_valid, bus_data, bus_owner, bus_busy, beat_count, overrun, grant_err);
    else n_pass++;
    step();
    n_checks++;
    if (bus_busy !== 1'b1 || bus_owner !== 2'd3 || beat_count !== '0)
      $display("FAIL midreset_regrant: got busy=%b owner=%0d cnt=%0d, expected busy=1 owner=3 cnt=0",
               bus_busy, bus_owner, beat_count);
    else n_pass++;
    valid_3 = 1'b1; data_3 = 8'hD5;
    sb_q.push_back(data_3);
    step();
    n_checks++;
    if (beat_count !== CNT_W'(1)) $display("FAIL midreset_restart: got cnt=%0d, expected 1", beat_count);
    else n_pass++;
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_back_to_back();
    gnt_2 = 1'b1;
    step();
    gnt_2 = 1'b0;
    step();
    gnt_1 = 1'b1;
    step();
    n_checks++;
    if (bus_busy !== 1'b0 || grant_err !== 1'b0)
      $display("FAIL b2b_cooldown_ignores: got busy=%b err=%b, expected busy=0 err=0", bus_busy, grant_err);
    else n_pass++;
    step();
    n_checks++;
    if (bus_busy !== 1'b1 || bus_owner !== 2'd1)
      $display("FAIL b2b_capture: got busy=%b owner=%0d, expected busy=1 owner=1", bus_busy, bus_owner);
    else n_pass++;
    clear_inputs();
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_normal();
    test_overrun();
    test_illegal();
    test_nonowner();
    test_midreset();
    test_back_to_back();
    step();
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL sb_drain: got %0d beats outstanding, expected 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
